pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding selects, load-use stall, branch flush and memory-wait freeze.
// Latency: forwarding and all control outputs are combinational from inputs and current FSM state.
// Backpressure: an outstanding data-memory access freezes the whole pipe; a load-use hit stalls IF/ID for LOAD_LAT cycles.
module pipeline_hazard_ctrl #(
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC*5-1:0]   id_rs_addr,
  input  logic [NUM_SRC-1:0]     id_rs_used,
  input  logic [NUM_SRC*5-1:0]   ex_rs_addr,
  input  logic [4:0]             ex_rd_addr,
  input  logic                   ex_regwrite,
  input  logic                   ex_memread,
  input  logic [4:0]             mem_rd_addr,
  input  logic                   mem_regwrite,
  input  logic                   mem_memread,
  input  logic [4:0]             wb_rd_addr,
  input  logic                   wb_regwrite,
  input  logic                   ex_branch_taken,
  input  logic                   dmem_ready,
  output logic [NUM_SRC*2-1:0]   forward_sel,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   flush_id,
  output logic                   flush_ex,
  output logic                   freeze,
  output logic [1:0]             hazard_state,
  output logic [CNT_W-1:0]       stall_cycles
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_t;

  // The detection cycle itself is the first bubble, so LU_STALL covers the remaining LOAD_LAT-1.
  localparam logic [1:0] LU_INIT  = 2'(LOAD_LAT - 1);
  localparam bit         LU_MULTI = (LOAD_LAT > 1);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] lu_cnt;
  logic [1:0] lu_cnt_nxt;
  logic       lu_src_match;
  logic       lu_hit;
  logic       freeze_req;

  // Forwarding selects: EX/MEM result wins over MEM/WB; register x0 is never forwarded.
  always_comb begin
    forward_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mem_regwrite && (mem_rd_addr != 5'd0) && (mem_rd_addr == ex_rs_addr[5*i +: 5])) begin
        forward_sel[2*i +: 2] = 2'b10;
      end else if (wb_regwrite && (wb_rd_addr != 5'd0) && (wb_rd_addr == ex_rs_addr[5*i +: 5])) begin
        forward_sel[2*i +: 2] = 2'b01;
      end
    end
  end

  // Load-use detection: a load in EX whose destination is read by any used source slot in ID.
  always_comb begin
    lu_src_match = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] && (id_rs_addr[5*i +: 5] == ex_rd_addr)) begin
        lu_src_match = 1'b1;
      end
    end
    lu_hit     = ex_memread && ex_regwrite && (ex_rd_addr != 5'd0) && lu_src_match;
    freeze_req = mem_memread && !dmem_ready;
  end

  // State register and load-use bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      lu_cnt <= 2'd0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
    end
  end

  // Next-state logic. MEM_WAIT with the access complete behaves exactly like RUN for that cycle.
  always_comb begin
    state_nxt  = state;
    lu_cnt_nxt = lu_cnt;
    case (state)
      ST_RUN, ST_MEM_WAIT: begin
        if (freeze_req) begin
          state_nxt  = ST_MEM_WAIT;
          lu_cnt_nxt = 2'd0;
        end else if (ex_branch_taken) begin
          state_nxt  = ST_RUN;
          lu_cnt_nxt = 2'd0;
        end else if (lu_hit && LU_MULTI) begin
          state_nxt  = ST_LU_STALL;
          lu_cnt_nxt = LU_INIT;
        end else begin
          state_nxt  = ST_RUN;
          lu_cnt_nxt = 2'd0;
        end
      end
      ST_LU_STALL: begin
        if (freeze_req) begin
          // Abandon the stall; the hazard is re-detected once memory completes.
          state_nxt  = ST_MEM_WAIT;
          lu_cnt_nxt = 2'd0;
        end else if (ex_branch_taken) begin
          state_nxt  = ST_RUN;
          lu_cnt_nxt = 2'd0;
        end else if (lu_cnt <= 2'd1) begin
          state_nxt  = ST_RUN;
          lu_cnt_nxt = 2'd0;
        end else begin
          lu_cnt_nxt = lu_cnt - 2'd1;
        end
      end
      default: begin
        state_nxt  = ST_RUN;
        lu_cnt_nxt = 2'd0;
      end
    endcase
  end

  // Control outputs by state with priority freeze > branch > load-use; all forced low during reset.
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    freeze   = 1'b0;
    if (rst_n) begin
      case (state)
        ST_RUN, ST_MEM_WAIT: begin
          if (freeze_req) begin
            freeze = 1'b1;
          end else if (ex_branch_taken) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
          end else if (lu_hit) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
          end
        end
        ST_LU_STALL: begin
          if (freeze_req) begin
            freeze = 1'b1;
          end else if (ex_branch_taken) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
          end else begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
          end
        end
        default: begin
          freeze = 1'b0;
        end
      endcase
    end
  end

  assign hazard_state = state;

  // Saturating count of cycles in which the pipe is stalled or frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if ((stall_id || freeze) && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (LOAD_LAT=2, CNT_W=4).
// Stimulus pushes expected output vectors; a monitor pops and compares one per falling edge.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [9:0]  id_rs_addr;
  logic [1:0]  id_rs_used;
  logic [9:0]  ex_rs_addr;
  logic [4:0]  ex_rd_addr;
  logic        ex_regwrite;
  logic        ex_memread;
  logic [4:0]  mem_rd_addr;
  logic        mem_regwrite;
  logic        mem_memread;
  logic [4:0]  wb_rd_addr;
  logic        wb_regwrite;
  logic        ex_branch_taken;
  logic        dmem_ready;
  logic [3:0]  forward_sel;
  logic        stall_if;
  logic        stall_id;
  logic        flush_id;
  logic        flush_ex;
  logic        freeze;
  logic [1:0]  hazard_state;
  logic [3:0]  stall_cycles;

  int          tests = 0;
  int          fails = 0;
  logic [14:0] exp_q[$];
  string       name_q[$];

  pipeline_hazard_ctrl #(.NUM_SRC(2), .LOAD_LAT(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used), .ex_rs_addr(ex_rs_addr),
    .ex_rd_addr(ex_rd_addr), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd_addr(mem_rd_addr), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd_addr(wb_rd_addr), .wb_regwrite(wb_regwrite),
    .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready),
    .forward_sel(forward_sel), .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .flush_ex(flush_ex), .freeze(freeze),
    .hazard_state(hazard_state), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector order: {stall_if, stall_id, flush_id, flush_ex, freeze}
  localparam logic [4:0] C_NONE   = 5'b00000;
  localparam logic [4:0] C_STALL  = 5'b11010;
  localparam logic [4:0] C_FLUSH  = 5'b00110;
  localparam logic [4:0] C_FREEZE = 5'b00001;

  task automatic idle();
    id_rs_addr = '0; id_rs_used = '0; ex_rs_addr = '0;
    ex_rd_addr = '0; ex_regwrite = 0; ex_memread = 0;
    mem_rd_addr = '0; mem_regwrite = 0; mem_memread = 0;
    wb_rd_addr = '0; wb_regwrite = 0;
    ex_branch_taken = 0; dmem_ready = 1;
  endtask

  // Load in EX writing r7, instruction in ID reads r7 on slot 1 (slot 0 reads r3).
  task automatic lu_in(input logic [1:0] used);
    ex_memread = 1; ex_regwrite = 1; ex_rd_addr = 5'd7;
    id_rs_addr = {5'd7, 5'd3}; id_rs_used = used;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_vec(input logic [3:0] fwd, input logic [4:0] ctl,
                            input logic [1:0] st, input logic [3:0] cnt, input string nm);
    exp_q.push_back({fwd, ctl, st, cnt});
    name_q.push_back(nm);
  endtask

  // Monitor: one comparison per queued expectation, sampled mid-cycle.
  initial begin
    logic [14:0] e;
    logic [14:0] a;
    string       nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {forward_sel, stall_if, stall_id, flush_id, flush_ex, freeze, hazard_state, stall_cycles};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL %s: got fwd=%b ctl=%b st=%b cnt=%0d, required fwd=%b ctl=%b st=%b cnt=%0d",
                   nm, a[14:11], a[10:6], a[5:4], a[3:0], e[14:11], e[10:6], e[5:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 0;
    idle();
    // Reset with every hazard request active: controls low, forwarding still live.
    repeat (2) begin
      cyc();
      ex_rs_addr = {5'd0, 5'd5}; mem_regwrite = 1; mem_rd_addr = 5'd5;
      mem_memread = 1; dmem_ready = 0; ex_branch_taken = 1; lu_in(2'b10);
      expect_vec(4'b0010, C_NONE, 2'b00, 4'd0, "reset_hold");
    end
    cyc(); rst_n = 1;
    expect_vec(4'b0000, C_NONE, 2'b00, 4'd0, "reset_release");

    // Forwarding
    cyc(); ex_rs_addr = {5'd9, 5'd5}; mem_regwrite = 1; mem_rd_addr = 5'd5; wb_regwrite = 1; wb_rd_addr = 5'd5;
    expect_vec(4'b0010, C_NONE, 2'b00, 4'd0, "fwd_mem_priority");
    cyc(); ex_rs_addr = {5'd9, 5'd5}; mem_regwrite = 1; mem_rd_addr = 5'd0; wb_regwrite = 1; wb_rd_addr = 5'd5;
    expect_vec(4'b0001, C_NONE, 2'b00, 4'd0, "fwd_mem_x0");
    cyc(); ex_rs_addr = {5'd9, 5'd5}; mem_regwrite = 1; mem_rd_addr = 5'd9; wb_regwrite = 1; wb_rd_addr = 5'd5;
    expect_vec(4'b1001, C_NONE, 2'b00, 4'd0, "fwd_two_slots");
    cyc(); ex_rs_addr = {5'd9, 5'd5}; mem_regwrite = 0; mem_rd_addr = 5'd5; wb_regwrite = 1; wb_rd_addr = 5'd9;
    expect_vec(4'b0100, C_NONE, 2'b00, 4'd0, "fwd_no_regwrite");
    cyc(); ex_rs_addr = {5'd0, 5'd0}; wb_regwrite = 1; wb_rd_addr = 5'd0;
    expect_vec(4'b0000, C_NONE, 2'b00, 4'd0, "fwd_wb_x0");

    // Load-use stall, LOAD_LAT=2 bubbles
    cyc(); lu_in(2'b10);
    expect_vec(4'b0000, C_STALL, 2'b00, 4'd0, "lu_detect");
    cyc(); id_rs_addr = {5'd7, 5'd3}; id_rs_used = 2'b10;
    expect_vec(4'b0000, C_STALL, 2'b01, 4'd1, "lu_stall2");
    cyc(); id_rs_addr = {5'd7, 5'd3}; id_rs_used = 2'b10;
    expect_vec(4'b0000, C_NONE, 2'b00, 4'd2, "lu_release");
    cyc();
    expect_vec(4'b0000, C_NONE, 2'b00, 4'd2, "lu_after");

    // Unused slot, and branch overriding a hit
    cyc(); lu_in(2'b01);
    expect_vec(4'b0000, C_NONE, 2'b00, 4'd2, "lu_unused_slot");
    cyc(); lu_in(2'b10); ex_branch_taken = 1;
    expect_vec(4'b0000, C_FLUSH, 2'b00, 4'd2, "branch_over_lu");
    cyc();
    expect_vec(4'b0000, C_NONE, 2'b00, 4'd2, "branch_stays_run");

    // Branch during LU_STALL
    cyc(); lu_in(2'b10);
    expect_vec(4'b0000, C_STALL, 2'b00, 4'd2, "lu_detect_b");
    cyc(); ex_branch_taken = 1;
    expect_vec(4'b0000, C_FLUSH, 2'b01, 4'd3, "lu_stall_branch");
    cyc();
    expect_vec(4'b0000, C_NONE, 2'b00, 4'd3, "lu_branch_exit");

    // Memory wait: freeze beats branch and load-use; exit applies RUN rules the same cycle
    cyc(); mem_memread = 1; dmem_ready = 0; ex_branch_taken = 1; lu_in(2'b10);
    expect_vec(4'b0000, C_FREEZE, 2'b00, 4'd3, "freeze_priority");
    cyc(); mem_memread = 1; dmem_ready = 0; ex_branch_taken = 1;
    ex_rs_addr = {5'd0, 5'd5}; wb_regwrite = 1; wb_rd_addr = 5'd5;
    expect_vec(4'b0001, C_FREEZE, 2'b10, 4'd4, "freeze_fwd_live");
    cyc(); mem_memread = 1; dmem_ready = 0;
    expect_vec(4'b0000, C_FREEZE, 2'b10, 4'd5, "freeze_third");
    cyc(); mem_memread = 1; dmem_ready = 1; lu_in(2'b10);
    expect_vec(4'b0000, C_STALL, 2'b10, 4'd6, "freeze_exit_lu");
    cyc();
    expect_vec(4'b0000, C_STALL, 2'b01, 4'd7, "freeze_exit_lu_stall");
    cyc();
    expect_vec(4'b0000, C_NONE, 2'b00, 4'd8, "freeze_exit_run");

    // Load-use stall interrupted by freeze, re-detected afterwards
    cyc(); lu_in(2'b10);
    expect_vec(4'b0000, C_STALL, 2'b00, 4'd8, "lu_int_detect");
    cyc(); mem_memread = 1; dmem_ready = 0;
    expect_vec(4'b0000, C_FREEZE, 2'b01, 4'd9, "lu_int_freeze");
    cyc(); mem_memread = 1; dmem_ready = 0;
    expect_vec(4'b0000, C_FREEZE, 2'b10, 4'd10, "lu_int_wait");
    cyc(); mem_memread = 1; dmem_ready = 1; lu_in(2'b10);
    expect_vec(4'b0000, C_STALL, 2'b10, 4'd11, "lu_int_redetect");
    cyc();
    expect_vec(4'b0000, C_STALL, 2'b01, 4'd12, "lu_int_stall2");
    cyc();
    expect_vec(4'b0000, C_NONE, 2'b00, 4'd13, "lu_int_done");

    // Asynchronous reset in LU_STALL (no clock edge between assertion and check)
    cyc(); lu_in(2'b10);
    expect_vec(4'b0000, C_STALL, 2'b00, 4'd13, "rst_pre_detect");
    cyc(); #1; rst_n = 0;
    expect_vec(4'b0000, C_NONE, 2'b00, 4'd0, "rst_async_lu");
    cyc(); lu_in(2'b10); mem_memread = 1; dmem_ready = 0;
    expect_vec(4'b0000, C_NONE, 2'b00, 4'd0, "rst_ctl_low");
    cyc(); rst_n = 1;
    expect_vec(4'b0000, C_NONE, 2'b00, 4'd0, "rst_no_residual");
    cyc();
    expect_vec(4'b0000, C_NONE, 2'b00, 4'd0, "rst_no_residual2");

    // Stall counter saturation at 15 with a 20-cycle freeze
    for (int k = 1; k <= 20; k++) begin
      cyc(); mem_memread = 1; dmem_ready = 0;
      expect_vec(4'b0000, C_FREEZE, (k == 1) ? 2'b00 : 2'b10,
                 (k - 1 > 15) ? 4'd15 : 4'(k - 1), "sat_freeze");
    end
    cyc(); mem_memread = 1; dmem_ready = 1;
    expect_vec(4'b0000, C_NONE, 2'b10, 4'd15, "sat_exit");
    cyc();
    expect_vec(4'b0000, C_NONE, 2'b00, 4'd15, "sat_hold");

    // Let the monitor drain, bounded
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
